// File: rtl/ascon_block_seq_pkg.sv
// ascon_pack: sequencer state type, phase codes and watchdog limit for the ASCON block sequencer
package ascon_pack;
  typedef enum logic [2:0] {IDLE, LD_AD, WT_AD, LD_PT, WT_PT, FINAL, WT_FIN} seq_state_t;
  localparam logic [1:0] PHASE_IDLE = 2'b00;
  localparam logic [1:0] PHASE_AD = 2'b01;
  localparam logic [1:0] PHASE_PT = 2'b10;
  localparam logic [1:0] PHASE_FIN = 2'b11;
  localparam int SEQ_TIMEOUT = 255;
  function automatic logic [1:0] phase_of(input seq_state_t s);
    return (s == LD_AD || s == WT_AD) ? PHASE_AD :
           (s == LD_PT || s == WT_PT) ? PHASE_PT :
           (s == FINAL || s == WT_FIN) ? PHASE_FIN : PHASE_IDLE;
  endfunction
endpackage

// File: rtl/ascon_block_seq_rem_cnt.sv
// seq_rem_cnt: loadable down-counter of blocks remaining in the current phase, with zero/one flags
module seq_rem_cnt #(parameter int W = 4) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero,
  output logic         one
);
  logic [W-1:0] cnt;
  always_ff @(posedge clock_i)
    if (!resetb_i) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec) cnt <= cnt - W'(1);
  assign zero = cnt == '0;
  assign one = cnt == W'(1);
endmodule

// File: rtl/ascon_block_seq.sv
// ascon_block_seq: AD/PT block fetch and permutation sequencer; ASCON_SEQ_TIMEOUT_EN adds a wait-state watchdog
module ascon_block_seq
  import ascon_pack::*;
#(parameter int CPT_W = 4) (
  input  logic             clock_i,
  input  logic             resetb_i,
  input  logic             start_i,
  input  logic [CPT_W-1:0] nb_ad_i,
  input  logic [CPT_W-1:0] nb_pt_i,
  input  logic             blk_valid_i,
  output logic             blk_ready_o,
  output logic             perm_start_o,
  input  logic             perm_done_i,
  output logic             init_block_o,
  output logic             en_block_o,
  output logic [CPT_W-1:0] blk_idx_o,
  output logic [1:0]       phase_o,
  output logic             last_block_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o
);
  seq_state_t state, nxt;
  logic [CPT_W-1:0] pt_q, start_pt, load_val, idx_n;
  logic load, dec, rem_zero, rem_one, hs, init_n, en_n, ps_n, done_n, last_n, tmo;
  assign start_pt = (nb_pt_i == '0) ? CPT_W'(1) : nb_pt_i;
  assign blk_ready_o = (state == LD_AD) || (state == LD_PT);
  assign hs = blk_valid_i & blk_ready_o;
  seq_rem_cnt #(.W(CPT_W)) u_rem (
    .clock_i(clock_i), .resetb_i(resetb_i), .load(load), .dec(dec),
    .load_val(load_val), .zero(rem_zero), .one(rem_one)
  );
  always_comb begin
    nxt = state;
    load = 1'b0;
    dec = 1'b0;
    load_val = pt_q;
    idx_n = blk_idx_o;
    init_n = 1'b0;
    en_n = 1'b0;
    ps_n = 1'b0;
    done_n = 1'b0;
    case (state)
      IDLE: if (start_i) begin
        nxt = (nb_ad_i != '0) ? LD_AD : LD_PT;
        load = 1'b1;
        load_val = (nb_ad_i != '0) ? nb_ad_i : start_pt;
        idx_n = '0;
        init_n = 1'b1;
        en_n = 1'b1;
      end
      LD_AD, LD_PT: if (hs) begin
        nxt = (state == LD_AD) ? WT_AD : WT_PT;
        dec = 1'b1;
        ps_n = 1'b1;
        en_n = 1'b1;
      end
      WT_AD: if (perm_done_i) begin
        nxt = rem_zero ? LD_PT : LD_AD;
        load = rem_zero;
        idx_n = rem_zero ? '0 : blk_idx_o + CPT_W'(1);
        init_n = rem_zero;
        en_n = rem_zero;
      end
      WT_PT: if (perm_done_i) begin
        nxt = rem_zero ? FINAL : LD_PT;
        ps_n = rem_zero;
        idx_n = rem_zero ? blk_idx_o : blk_idx_o + CPT_W'(1);
      end
      FINAL: nxt = WT_FIN;
      WT_FIN: if (perm_done_i) begin
        nxt = IDLE;
        done_n = 1'b1;
      end
      default: nxt = IDLE;
    endcase
    if (tmo) nxt = IDLE;
    // LD states hold rem steady, so the flag after any load/dec is known one cycle early
    last_n = (nxt == LD_AD || nxt == LD_PT) && (load ? load_val == CPT_W'(1) : rem_one);
  end
  always_ff @(posedge clock_i) state <= !resetb_i ? IDLE : nxt;
  always_ff @(posedge clock_i)
    if (!resetb_i) begin
      pt_q <= '0;
      {init_block_o, en_block_o, perm_start_o, done_o, last_block_o, busy_o} <= '0;
      blk_idx_o <= '0;
      phase_o <= PHASE_IDLE;
    end else begin
      pt_q <= (state == IDLE && start_i) ? start_pt : pt_q;
      init_block_o <= init_n;
      en_block_o <= en_n;
      perm_start_o <= ps_n;
      done_o <= done_n;
      last_block_o <= last_n;
      busy_o <= nxt != IDLE;
      blk_idx_o <= idx_n;
      phase_o <= phase_of(nxt);
    end
`ifdef ASCON_SEQ_TIMEOUT_EN
  logic [7:0] wd;
  logic in_wt;
  assign in_wt = (state == WT_AD) || (state == WT_PT) || (state == WT_FIN);
  assign tmo = in_wt && !perm_done_i && wd == 8'(SEQ_TIMEOUT - 1);
  always_ff @(posedge clock_i)
    if (!resetb_i) begin
      wd <= '0;
      error_o <= 1'b0;
    end else begin
      wd <= (in_wt && nxt == state) ? wd + 8'd1 : 8'd0;
      error_o <= tmo ? 1'b1 : (state == IDLE && start_i) ? 1'b0 : error_o;
    end
`else
  assign tmo = 1'b0;
  assign error_o = 1'b0;
`endif
endmodule

// File: tb/tb_ascon_block_seq.sv
// tb_ascon_block_seq: randomized bench with a transaction-level model of the block sequencer
module tb_ascon_block_seq;
  localparam int W = 4;
  logic clock_i = 1'b0;
  logic resetb_i, start_i, blk_valid_i, perm_done_i;
  logic [W-1:0] nb_ad_i, nb_pt_i, blk_idx_o;
  logic blk_ready_o, perm_start_o, init_block_o, en_block_o, last_block_o, busy_o, done_o, error_o;
  logic [1:0] phase_o;
  always #5 clock_i = ~clock_i;
  ascon_block_seq #(.CPT_W(W)) dut (
    .clock_i(clock_i), .resetb_i(resetb_i), .start_i(start_i), .nb_ad_i(nb_ad_i), .nb_pt_i(nb_pt_i),
    .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o), .perm_start_o(perm_start_o),
    .perm_done_i(perm_done_i), .init_block_o(init_block_o), .en_block_o(en_block_o),
    .blk_idx_o(blk_idx_o), .phase_o(phase_o), .last_block_o(last_block_o), .busy_o(busy_o),
    .done_o(done_o), .error_o(error_o)
  );
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // model: the ordered list of blocks a command must fetch, plus what each permutation completion leads to
  typedef struct {int ph; int idx; int last;} blk_t;
  blk_t q[$];
  bit armed = 0, post_rst = 0, mbusy = 0, mready = 0;
  bit e_ps = 0, e_init = 0, e_en = 0, e_done = 0;
  int outst = 0, cur_ph = 0;
  int ps_cnt = 0, init_cnt = 0, done_cnt = 0;
  int idx_log[$], ph_log[$], last_log[$];
  task automatic clear_logs();
    ps_cnt = 0; init_cnt = 0; done_cnt = 0;
    idx_log.delete(); last_log.delete(); ph_log.delete();
    ph_log.push_back(0);
  endtask
  task automatic load_cmd(input int ad, input int pt);
    int pe;
    pe = (pt == 0) ? 1 : pt;
    for (int i = 0; i < ad; i++) q.push_back('{1, i, int'(i == ad - 1)});
    for (int i = 0; i < pe; i++) q.push_back('{2, i, int'(i == pe - 1)});
  endtask
  always @(negedge clock_i) begin
    blk_t b;
    if (armed) begin
      chk("perm_start", perm_start_o, e_ps);
      chk("init_block", init_block_o, e_init);
      chk("en_block", en_block_o, e_en);
      chk("done", done_o, e_done);
      chk("busy", busy_o, mbusy);
      chk("blk_ready", blk_ready_o, mready);
      chk("error", error_o, 0);
      if (mready && q.size() > 0) begin
        chk("ld_phase", phase_o, q[0].ph);
        chk("ld_blk_idx", blk_idx_o, q[0].idx);
        chk("ld_last_block", last_block_o, q[0].last);
      end else begin
        chk("last_block_off", last_block_o, 0);
        if (!mbusy) chk("idle_phase", phase_o, 0);
        else if (outst >= 4) chk("final_phase", phase_o, 3);
        else if (outst != 0) chk("wait_phase", phase_o, cur_ph);
      end
      if (perm_start_o) ps_cnt++;
      if (init_block_o) init_cnt++;
      if (done_o) done_cnt++;
      if (ph_log.size() > 0 && phase_o != ph_log[$]) ph_log.push_back(phase_o);
    end
    if (post_rst) begin
      chk("rst_phase", phase_o, 0);
      chk("rst_blk_idx", blk_idx_o, 0);
      chk("rst_last", last_block_o, 0);
    end
    post_rst = !resetb_i;
    if (!resetb_i) begin
      q.delete();
      {mbusy, mready, e_ps, e_init, e_en, e_done} = '0;
      outst = 0;
      armed = 1;
    end else if (armed) begin
      {e_ps, e_init, e_en, e_done} = '0;
      if (!mbusy && start_i) begin
        load_cmd(nb_ad_i, nb_pt_i);
        mbusy = 1; mready = 1; e_init = 1; e_en = 1;
      end else if (mready && blk_valid_i && q.size() > 0) begin
        b = q.pop_front();
        cur_ph = b.ph;
        idx_log.push_back(blk_idx_o);
        last_log.push_back(last_block_o);
        e_ps = 1; e_en = 1; mready = 0;
        outst = b.last == 0 ? 1 : (b.ph == 1 ? 2 : 3);
      end else if (outst == 5) outst = 4;
      else if (!mready && perm_done_i && outst != 0) begin
        case (outst)
          1: begin mready = 1; outst = 0; end
          2: begin mready = 1; e_init = 1; e_en = 1; outst = 0; end
          3: begin e_ps = 1; outst = 5; end
          default: begin e_done = 1; mbusy = 0; outst = 0; end
        endcase
      end
    end
  end
  // permutation core stand-in: answers each launch after dly cycles (0 = random 1..3)
  int dly = 2, cd = 0;
  bit hold_done = 0, spur_done = 0;
  initial begin
    perm_done_i = 1'b0;
    forever begin
      @(posedge clock_i);
      #1;
      perm_done_i = (cd == 1) || spur_done;
      if (cd > 0) cd--;
      if (!resetb_i) cd = 0;
      else if (perm_start_o && !hold_done) cd = (dly > 0) ? dly : int'($urandom_range(1, 3));
    end
  end
  task automatic step();
    @(posedge clock_i);
    #1;
  endtask
  task automatic do_start(input int ad, input int pt);
    nb_ad_i = W'(ad); nb_pt_i = W'(pt); start_i = 1'b1;
    step();
    start_i = 1'b0; nb_ad_i = W'($urandom); nb_pt_i = W'($urandom);
  endtask
  task automatic wait_done(input int vprob, input bit spur);
    int n;
    n = 0;
    while (!done_o && n < 3000) begin
      blk_valid_i = $urandom_range(0, 99) < vprob;
      start_i = spur && busy_o && $urandom_range(0, 3) == 0;
      nb_ad_i = W'($urandom); nb_pt_i = W'($urandom);
      step();
      n++;
    end
    start_i = 1'b0; blk_valid_i = 1'b0;
    chk("done_reached", done_o, 1);
  endtask
  task automatic wait_ready(input bit lvl);
    int n;
    n = 0;
    while (blk_ready_o != lvl && n < 50) begin step(); n++; end
    chk("ready_reached", blk_ready_o, lvl);
  endtask
  initial begin
    int exp_idx[5] = '{0, 1, 0, 1, 2};
    int exp_ph[4] = '{0, 2, 3, 0};
    int n;
    resetb_i = 1'b0; start_i = 1'b0; blk_valid_i = 1'b0; nb_ad_i = '0; nb_pt_i = '0;
    repeat (3) step();
    resetb_i = 1'b1;
    step();
    chk("reset_busy", busy_o, 0);
    chk("reset_ready", blk_ready_o, 0);
    chk("reset_error", error_o, 0);
    clear_logs(); dly = 2;
    do_start(2, 3); wait_done(100, 0); step();
    chk("s1_perm_starts", ps_cnt, 6);
    chk("s1_init_pulses", init_cnt, 2);
    chk("s1_done_pulses", done_cnt, 1);
    chk("s1_blocks", idx_log.size(), 5);
    for (int i = 0; i < 5 && i < idx_log.size(); i++) chk("s1_idx_seq", idx_log[i], exp_idx[i]);
    clear_logs(); dly = 0;
    do_start(0, 0); wait_done(100, 0); step();
    chk("s2_phase_steps", ph_log.size(), 4);
    for (int i = 0; i < 4 && i < ph_log.size(); i++) chk("s2_phase_seq", ph_log[i], exp_ph[i]);
    chk("s2_blocks", last_log.size(), 1);
    if (last_log.size() > 0) chk("s2_last", last_log[0], 1);
    clear_logs();
    do_start(0, 2); blk_valid_i = 1'b0; wait_ready(1);
    for (int i = 0; i < 10; i++) begin
      spur_done = (i == 4);
      step();
      chk("s3_hold_ready", blk_ready_o, 1);
      chk("s3_hold_no_perm", perm_start_o, 0);
    end
    spur_done = 1'b0;
    wait_done(100, 0); step();
    chk("s3_perm_starts", ps_cnt, 3);
    do_start(0, 4); blk_valid_i = 1'b1;
    wait_ready(0); wait_ready(1); wait_ready(0);
    blk_valid_i = 1'b0; resetb_i = 1'b0;
    step();
    chk("s4_busy", busy_o, 0); chk("s4_ready", blk_ready_o, 0); chk("s4_perm", perm_start_o, 0);
    chk("s4_init", init_block_o, 0); chk("s4_en", en_block_o, 0); chk("s4_idx", blk_idx_o, 0);
    chk("s4_phase", phase_o, 0); chk("s4_last", last_block_o, 0); chk("s4_done", done_o, 0);
    chk("s4_error", error_o, 0);
    resetb_i = 1'b1; step(); step();
    clear_logs();
    do_start(1, 2); wait_done(70, 0); step();
    chk("s4_clean_perm_starts", ps_cnt, 4);
    clear_logs();
    do_start(1, 2); wait_done(60, 1); step();
    chk("s5_perm_starts", ps_cnt, 4);
    chk("s5_done_pulses", done_cnt, 1);
    for (int k = 0; k < 15; k++) begin
      dly = 0;
      do_start($urandom_range(0, 3), $urandom_range(0, 4));
      wait_done($urandom_range(30, 100), 1'($urandom_range(0, 1)));
      step();
    end
`ifdef ASCON_SEQ_TIMEOUT_EN
    armed = 0; hold_done = 1;
    do_start(0, 1); blk_valid_i = 1'b1; wait_ready(0); blk_valid_i = 1'b0;
    n = 0;
    while (!error_o && n < 300) begin step(); n++; end
    chk("to_cycles_in_window", int'(n >= 253 && n <= 257), 1);
    chk("to_error", error_o, 1);
    chk("to_busy", busy_o, 0);
    hold_done = 0;
    do_start(0, 1);
    chk("to_error_cleared", error_o, 0);
    wait_done(100, 0);
    resetb_i = 1'b0; step(); resetb_i = 1'b1; step();
`else
    n = 0;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end
endmodule
